// File: rtl/armleocpu_avl_arbiter_if.sv
// Single-beat Avalon-MM bus bundle shared by the arbiter's master and slave sides.
// The master modport is the side that issues commands; the slave modport answers them.
interface armleocpu_avl_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [1:0]  response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest, response
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid, waitrequest, response
  );
endinterface

// File: rtl/armleocpu_avl_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter.
// m0 is the page-table walker (read-only, its write/writedata/byteenable are ignored),
// m1 is the load/store path. One single-beat transaction is in flight at a time;
// command fields are muxed combinationally from the owner, never latched.
module armleocpu_avl_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  armleocpu_avl_arbiter_if.slave  m0,
  armleocpu_avl_arbiter_if.slave  m1,
  armleocpu_avl_arbiter_if.master avl
);

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_CMD       = 2'd1,
    STATE_WAIT_READ = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   last_grant_reg, last_grant_next;

  logic req0, req1;
  logic cmd_read, cmd_write;

  assign req0 = m0.read;
  assign req1 = m1.read | m1.write;

  // Read data is broadcast; only readdatavalid tells a master the beat is its own.
  assign m0.readdata = avl.readdata;
  assign m1.readdata = avl.readdata;

  // Owner's command kind; a simultaneous read+write from m1 is forwarded as a read only.
  always_comb begin
    cmd_read  = owner_reg ? m1.read : m0.read;
    cmd_write = owner_reg ? (m1.write & ~m1.read) : 1'b0;
  end

  // State, owner and fairness history registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_reg      <= STATE_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Arbitration and transaction sequencing.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      STATE_IDLE: begin
        if (req0 && req1) begin
          owner_next = ROUND_ROBIN ? ~last_grant_reg : 1'b0;
          state_next = STATE_CMD;
        end else if (req1) begin
          owner_next = 1'b1;
          state_next = STATE_CMD;
        end else if (req0) begin
          owner_next = 1'b0;
          state_next = STATE_CMD;
        end
      end
      STATE_CMD: begin
        if (!avl.waitrequest) begin
          if (cmd_read) begin
            state_next = STATE_WAIT_READ;
          end else begin
            // Writes complete on accept; a vanished command also just releases the bus.
            state_next      = STATE_IDLE;
            last_grant_next = owner_reg;
          end
        end
      end
      STATE_WAIT_READ: begin
        if (avl.readdatavalid) begin
          state_next      = STATE_IDLE;
          last_grant_next = owner_reg;
        end
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  // Slave command mux, per-master stall and response routing.
  always_comb begin
    avl.address       = 32'h0;
    avl.read          = 1'b0;
    avl.write         = 1'b0;
    avl.writedata     = 32'h0;
    avl.byteenable    = 4'h0;
    m0.waitrequest    = 1'b1;
    m1.waitrequest    = 1'b1;
    m0.readdatavalid  = 1'b0;
    m1.readdatavalid  = 1'b0;
    m0.response       = 2'b00;
    m1.response       = 2'b00;
    case (state_reg)
      STATE_CMD: begin
        avl.address    = owner_reg ? m1.address : m0.address;
        avl.read       = cmd_read;
        avl.write      = cmd_write;
        avl.writedata  = owner_reg ? m1.writedata : 32'h0;
        avl.byteenable = owner_reg ? m1.byteenable : 4'hF;
        if (owner_reg) begin
          m1.waitrequest = avl.waitrequest;
        end else begin
          m0.waitrequest = avl.waitrequest;
        end
      end
      STATE_WAIT_READ: begin
        if (avl.readdatavalid) begin
          if (owner_reg) begin
            m1.readdatavalid = 1'b1;
            m1.response      = avl.response;
          end else begin
            m0.readdatavalid = 1'b1;
            m0.response      = avl.response;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_armleocpu_avl_arbiter.sv
// Bench for armleocpu_avl_arbiter: one round-robin and one fixed-priority instance share
// the same stimulus; the instance under test is picked by sel and reset at phase start.
// The reference model works per transaction: who wins, what the slave must see, and
// how many cycles each phase lasts.
module tb_armleocpu_avl_arbiter;

  logic clk = 1'b0;
  logic async_rst_n = 1'b1;
  always #5 clk = ~clk;

  // Stimulus driven by the bench
  logic [31:0] m0_address, m1_address, m1_writedata, avl_readdata;
  logic        m0_read, m1_read, m1_write, avl_readdatavalid, avl_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [1:0]  avl_response;

  // Observed outputs, one entry per instance
  logic [31:0] o_m0_rdata [2];
  logic [31:0] o_m1_rdata [2];
  logic        o_m0_rdv   [2];
  logic        o_m1_rdv   [2];
  logic        o_m0_wait  [2];
  logic        o_m1_wait  [2];
  logic [1:0]  o_m0_resp  [2];
  logic [1:0]  o_m1_resp  [2];
  logic [31:0] o_avl_addr [2];
  logic        o_avl_rd   [2];
  logic        o_avl_wr   [2];
  logic [31:0] o_avl_wd   [2];
  logic [3:0]  o_avl_be   [2];

  armleocpu_avl_arbiter_if m0_bus [2] ();
  armleocpu_avl_arbiter_if m1_bus [2] ();
  armleocpu_avl_arbiter_if avl_bus [2] ();

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign m0_bus[gi].address    = m0_address;
      assign m0_bus[gi].read       = m0_read;
      assign m0_bus[gi].write      = 1'b0;
      assign m0_bus[gi].writedata  = 32'h0;
      assign m0_bus[gi].byteenable = 4'h0;
      assign m1_bus[gi].address    = m1_address;
      assign m1_bus[gi].read       = m1_read;
      assign m1_bus[gi].write      = m1_write;
      assign m1_bus[gi].writedata  = m1_writedata;
      assign m1_bus[gi].byteenable = m1_byteenable;
      assign avl_bus[gi].readdata      = avl_readdata;
      assign avl_bus[gi].readdatavalid = avl_readdatavalid;
      assign avl_bus[gi].waitrequest   = avl_waitrequest;
      assign avl_bus[gi].response      = avl_response;

      armleocpu_avl_arbiter #(
        .ROUND_ROBIN((gi == 0) ? 1'b1 : 1'b0)
      ) u_dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .m0         (m0_bus[gi]),
        .m1         (m1_bus[gi]),
        .avl        (avl_bus[gi])
      );

      assign o_m0_rdata[gi] = m0_bus[gi].readdata;
      assign o_m1_rdata[gi] = m1_bus[gi].readdata;
      assign o_m0_rdv[gi]   = m0_bus[gi].readdatavalid;
      assign o_m1_rdv[gi]   = m1_bus[gi].readdatavalid;
      assign o_m0_wait[gi]  = m0_bus[gi].waitrequest;
      assign o_m1_wait[gi]  = m1_bus[gi].waitrequest;
      assign o_m0_resp[gi]  = m0_bus[gi].response;
      assign o_m1_resp[gi]  = m1_bus[gi].response;
      assign o_avl_addr[gi] = avl_bus[gi].address;
      assign o_avl_rd[gi]   = avl_bus[gi].read;
      assign o_avl_wr[gi]   = avl_bus[gi].write;
      assign o_avl_wd[gi]   = avl_bus[gi].writedata;
      assign o_avl_be[gi]   = avl_bus[gi].byteenable;
    end
  endgenerate

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;
  int txn_no   = 0;

  // Model state: pending master requests and fairness history
  bit          rr_mode;
  bit          lg_model;
  bit          p0, p1, p1_rd, p1_wr;
  logic [31:0] a0, a1, wd1;
  logic [3:0]  be1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d txn %0d): got %0h expected %0h", tag, sel, txn_no, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_masters();
    m0_read       = p0;
    m0_address    = p0 ? a0 : 32'h0;
    m1_read       = p1 & p1_rd;
    m1_write      = p1 & p1_wr;
    m1_address    = a1;
    m1_writedata  = wd1;
    m1_byteenable = be1;
  endtask

  // Bus idle from the masters' view: both stalled, no data, no slave command.
  task automatic check_quiet(input string tag);
    check_eq({tag, "_w0"}, 32'(o_m0_wait[sel]), 32'd1);
    check_eq({tag, "_w1"}, 32'(o_m1_wait[sel]), 32'd1);
    check_eq({tag, "_rdv0"}, 32'(o_m0_rdv[sel]), 32'd0);
    check_eq({tag, "_rdv1"}, 32'(o_m1_rdv[sel]), 32'd0);
    check_eq({tag, "_avlrd"}, 32'(o_avl_rd[sel]), 32'd0);
    check_eq({tag, "_avlwr"}, 32'(o_avl_wr[sel]), 32'd0);
    check_eq({tag, "_rdata0"}, o_m0_rdata[sel], avl_readdata);
    check_eq({tag, "_rdata1"}, o_m1_rdata[sel], avl_readdata);
  endtask

  // Reset is applied with a stray readdatavalid present; it must not leak through.
  task automatic do_reset();
    p0 = 1'b0;
    p1 = 1'b0;
    drive_masters();
    avl_waitrequest   = 1'b0;
    avl_readdatavalid = 1'b1;
    avl_response      = 2'b11;
    async_rst_n       = 1'b0;
    #1;
    check_quiet("rst");
    check_eq("rst_resp0", 32'(o_m0_resp[sel]), 32'd0);
    check_eq("rst_resp1", 32'(o_m1_resp[sel]), 32'd0);
    check_eq("rst_addr", o_avl_addr[sel], 32'h0);
    check_eq("rst_wd", o_avl_wd[sel], 32'h0);
    check_eq("rst_be", 32'(o_avl_be[sel]), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_n       = 1'b1;
    avl_readdatavalid = 1'b0;
    avl_response      = 2'b00;
    tick();
    lg_model = 1'b1;
  endtask

  // One cycle with nothing requested, optionally with a spurious slave beat.
  task automatic idle_cycle(input bit stray);
    drive_masters();
    avl_readdatavalid = stray;
    avl_readdata      = $urandom;
    @(negedge clk);
    check_quiet("idle");
    tick();
    avl_readdatavalid = 1'b0;
  endtask

  // One full arbitration + transaction from the current pending set.
  // w = slave wait cycles before accept, l = cycles from accept to readdatavalid.
  task automatic run_txn(input int w, input int l, input logic [31:0] rdata, input logic [1:0] resp);
    bit          own, is_rd, is_wr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    txn_no++;
    own      = (p0 && p1) ? (rr_mode ? ~lg_model : 1'b0) : p1;
    is_rd    = own ? p1_rd : 1'b1;
    is_wr    = own & p1_wr & ~p1_rd;
    exp_addr = own ? a1 : a0;
    exp_be   = own ? be1 : 4'hF;

    // Arbitration cycle
    drive_masters();
    avl_waitrequest   = 1'($urandom_range(0, 1));
    avl_readdatavalid = 1'($urandom_range(0, 1));
    avl_readdata      = $urandom;
    avl_response      = 2'($urandom);
    @(negedge clk);
    check_quiet("arb");
    tick();

    // Command phase
    for (int k = 0; k <= w; k++) begin
      avl_waitrequest   = (k < w);
      avl_readdatavalid = 1'($urandom_range(0, 1));
      avl_readdata      = $urandom;
      @(negedge clk);
      check_eq("cmd_addr", o_avl_addr[sel], exp_addr);
      check_eq("cmd_rd", 32'(o_avl_rd[sel]), 32'(is_rd));
      check_eq("cmd_wr", 32'(o_avl_wr[sel]), 32'(is_wr));
      check_eq("cmd_be", 32'(o_avl_be[sel]), 32'(exp_be));
      if (is_wr) check_eq("cmd_wd", o_avl_wd[sel], wd1);
      check_eq("cmd_w0", 32'(o_m0_wait[sel]), own ? 32'd1 : 32'(k < w));
      check_eq("cmd_w1", 32'(o_m1_wait[sel]), own ? 32'(k < w) : 32'd1);
      check_eq("cmd_rdv0", 32'(o_m0_rdv[sel]), 32'd0);
      check_eq("cmd_rdv1", 32'(o_m1_rdv[sel]), 32'd0);
      tick();
    end

    // Owner is done issuing; the loser keeps its request up.
    if (own) p1 = 1'b0;
    else     p0 = 1'b0;
    drive_masters();
    avl_waitrequest   = 1'($urandom_range(0, 1));
    avl_readdatavalid = 1'b0;

    if (is_rd) begin
      for (int j = 1; j <= l; j++) begin
        avl_readdatavalid = (j == l);
        avl_readdata      = (j == l) ? rdata : $urandom;
        avl_response      = (j == l) ? resp : 2'($urandom);
        @(negedge clk);
        check_quiet_wait(own, j == l, resp);
        tick();
      end
      avl_readdatavalid = 1'b0;
    end
    lg_model = own;
  endtask

  task automatic check_quiet_wait(input bit own, input bit last, input logic [1:0] resp);
    check_eq("wr_w0", 32'(o_m0_wait[sel]), 32'd1);
    check_eq("wr_w1", 32'(o_m1_wait[sel]), 32'd1);
    check_eq("wr_avlrd", 32'(o_avl_rd[sel]), 32'd0);
    check_eq("wr_avlwr", 32'(o_avl_wr[sel]), 32'd0);
    check_eq("wr_rdv0", 32'(o_m0_rdv[sel]), 32'(last & ~own));
    check_eq("wr_rdv1", 32'(o_m1_rdv[sel]), 32'(last & own));
    check_eq("wr_rdata0", o_m0_rdata[sel], avl_readdata);
    check_eq("wr_rdata1", o_m1_rdata[sel], avl_readdata);
    if (last && own)  check_eq("wr_resp1", 32'(o_m1_resp[sel]), 32'(resp));
    if (last && !own) check_eq("wr_resp0", 32'(o_m0_resp[sel]), 32'(resp));
  endtask

  task automatic random_phase(input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1;
        a0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        op    = $urandom_range(0, 9);
        p1    = 1'b1;
        p1_rd = (op < 4) || (op == 9);
        p1_wr = (op >= 4);
        a1    = $urandom;
        wd1   = $urandom;
        be1   = 4'($urandom);
      end
      if (p0 || p1) run_txn($urandom_range(0, 3), $urandom_range(1, 3), $urandom, 2'($urandom));
      else          idle_cycle(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    m0_address = 0; m0_read = 0; m1_address = 0; m1_read = 0; m1_write = 0;
    m1_writedata = 0; m1_byteenable = 0; avl_readdata = 0; avl_readdatavalid = 0;
    avl_waitrequest = 0; avl_response = 0;
    p0 = 0; p1 = 0; p1_rd = 0; p1_wr = 0; a0 = 0; a1 = 0; wd1 = 0; be1 = 0;

    // ---------------- round-robin instance ----------------
    sel = 0; rr_mode = 1'b1;
    do_reset();

    // Single PTW read with two slave wait cycles
    p0 = 1'b1; a0 = 32'h0000_1000;
    run_txn(2, 1, 32'hABCD_0001, 2'b00);
    // Spurious beat while idle
    idle_cycle(1'b1);

    // Tie after reset: PTW first, then LSU (PTW re-requests to form a second tie)
    do_reset();
    p0 = 1'b1; a0 = 32'h0000_2000;
    p1 = 1'b1; p1_rd = 1'b0; p1_wr = 1'b1; a1 = 32'h8000_0010; wd1 = 32'h1234_5678; be1 = 4'h3;
    run_txn(0, 1, 32'h0, 2'b00);
    p0 = 1'b1; a0 = 32'h0000_3000;
    run_txn(1, 1, 32'h0, 2'b00);
    run_txn(0, 1, 32'h5555_AAAA, 2'b00);

    // LSU read with error response
    p1 = 1'b1; p1_rd = 1'b1; p1_wr = 1'b0; a1 = 32'h4000_0000;
    run_txn(1, 2, 32'hDEAD_BEEF, 2'b10);
    idle_cycle(1'b0);

    // Reset pulsed while waiting for read data, then a late beat
    p0 = 1'b1; a0 = 32'h0000_4000;
    drive_masters();
    avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0;
    tick();
    tick();
    p0 = 1'b0;
    drive_masters();
    @(negedge clk);
    check_quiet("pre_rst");
    tick();
    do_reset();
    idle_cycle(1'b1);

    random_phase(300);

    // ---------------- fixed-priority instance ----------------
    sel = 1; rr_mode = 1'b0;
    p0 = 1'b0; p1 = 1'b0;
    do_reset();
    p1 = 1'b1; p1_rd = 1'b0; p1_wr = 1'b1; a1 = 32'h9000_0000; wd1 = 32'hCAFE_F00D; be1 = 4'hC;
    for (int i = 0; i < 3; i++) begin
      p0 = 1'b1; a0 = 32'h0000_5000 + 32'(i * 4);
      run_txn(1, 1, $urandom, 2'b00);
    end
    run_txn(0, 1, 32'h0, 2'b00);

    random_phase(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/armleocpu_avl_arbiter.md
# armleocpu_avl_arbiter

Two-master, one-slave Avalon-MM arbiter sharing the CPU's single memory port between the page-table walker (master 0, read-only) and the load/store/cache path (master 1, read/write). It grants one master at a time, forwards that master's single-beat command to the slave, and routes the read response back only to the owner. At most one transaction is outstanding at a time; burstcount is always 1.

## Interface
- ROUND_ROBIN, 1: 1 = round-robin between masters; 0 = fixed priority, master 0 (PTW) always wins a tie.
- clk  in  1  clock, all logic on rising edge.
- async_rst_n  in  1  asynchronous active-low reset.
- m0_address  in  32  PTW address.
- m0_read  in  1  PTW read request.
- m0_readdata  out  32  read data, driven from avl_readdata.
- m0_readdatavalid  out  1  read data valid for PTW.
- m0_waitrequest  out  1  stall to PTW.
- m0_response  out  2  slave response for PTW reads.
- m1_address  in  32  LSU address.
- m1_read  in  1  LSU read request.
- m1_write  in  1  LSU write request.
- m1_writedata  in  32  LSU write data.
- m1_byteenable  in  4  LSU byte enables.
- m1_readdata  out  32  read data, driven from avl_readdata.
- m1_readdatavalid  out  1  read data valid for LSU.
- m1_waitrequest  out  1  stall to LSU.
- m1_response  out  2  slave response for LSU reads.
- avl_address  out  32  slave address.
- avl_read  out  1  slave read.
- avl_write  out  1  slave write.
- avl_writedata  out  32  slave write data.
- avl_byteenable  out  4  slave byte enables; 4'hF for master 0.
- avl_readdata  in  32  slave read data.
- avl_readdatavalid  in  1  slave read data valid.
- avl_waitrequest  in  1  slave stall.
- avl_response  in  2  slave response, 2'b00 = OKAY.

## Operation
- Registers: state (IDLE, CMD, WAIT_READ), owner (0/1), last_grant (0/1).
- IDLE: req0 = m0_read; req1 = m1_read | m1_write. If only one request is asserted, owner <= that master. If both: with ROUND_ROBIN=1, owner <= !last_grant; with ROUND_ROBIN=0, owner <= 0. Any request moves state to CMD. No request keeps state IDLE.
- CMD: avl_address/read/write/writedata/byteenable are a combinational mux of the owner's inputs. The owner's waitrequest = avl_waitrequest; the non-owner's waitrequest = 1.
  - On !avl_waitrequest with a read: go to WAIT_READ.
  - On !avl_waitrequest with a write: go to IDLE and set last_grant <= owner. Writes are complete on accept.
- WAIT_READ: the slave command is deasserted. On avl_readdatavalid: owner's readdatavalid = 1 and owner's response = avl_response, then go to IDLE with last_grant <= owner.
- m1_read & m1_write both asserted is a protocol violation. The arbiter forwards the read only (avl_write = 0).
- Masters hold their commands stable while waitrequest is asserted (Avalon rule). The arbiter does not latch command fields.
- avl_readdatavalid outside WAIT_READ is dropped and reaches neither master.
- Error responses (avl_response != 0) are passed through unchanged. The arbiter does not retry.

## Timing
- Reset values (asynchronous):
  - state = IDLE, owner = 0, last_grant = 1 (PTW wins first tie).
  - avl_read = avl_write = 0; avl_address, avl_writedata, avl_byteenable = 0.
  - m0_/m1_waitrequest = 1; m0_/m1_readdatavalid = 0; m0_/m1_response = 0.
- In IDLE and WAIT_READ both waitrequests are 1 and avl_read/avl_write are 0.
- Latency: request seen in IDLE at cycle N, command on the slave at N+1. Accept with zero slave wait at N+1, so the owner sees waitrequest = 0 at N+1.
- Read data reaches the owner in the same cycle as avl_readdatavalid (combinational). The next arbitration happens in the following cycle.
- Minimum turnaround per transaction:
  - Write: 2 cycles.
  - Read: 3 cycles (readdatavalid the cycle after accept).
- readdata outputs carry avl_readdata unconditionally. Only readdatavalid is gated.
- Reset asserted mid-transaction forces IDLE immediately. A late readdatavalid after reset is dropped.

## Test plan
- Single PTW read, addr 32'h0000_1000, slave waitrequest 2 cycles, readdata 32'hABCD_0001 one cycle after accept → m0_readdatavalid = 1 with that data and response 2'b00; m1 sees no valid.
- Simultaneous m0_read and m1_write after reset, ROUND_ROBIN=1 → PTW is served first, then LSU write (avl_byteenable = m1 value). A repeated tie then grants m1 first.
- ROUND_ROBIN=0, both requesting continuously for 3 transactions → master 0 is granted every time; m1_waitrequest stays 1.
- LSU read returns avl_response = 2'b10 → m1_response = 2'b10 with m1_readdatavalid, then the arbiter returns to IDLE.
- async_rst_n pulsed low during WAIT_READ, then a stray avl_readdatavalid → all outputs return to reset values; the stray beat is dropped.
- Spurious avl_readdatavalid while IDLE → no readdatavalid to either master.
